// File: rtl/dmem_bridge.sv
// dmem_bridge: D-mem request pulse -> ready/valid bus, one dm_resp_valid per request, 2-cycle load-to-use on a zero-wait bus.
// Holds the request while bus_req_ready is low, aborts after TIMEOUT_CYCLES; define DMEM_BRIDGE_POSTED_WRITE_EN to ack stores early.
module dmem_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter logic [63:0] ERR_RDATA      = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] dm_req_addr,
  input  logic [63:0] dm_req_wdata,
  input  logic [7:0]  dm_req_wmask,
  input  logic        dm_req_wen,
  input  logic        dm_req_valid,
  output logic [63:0] dm_resp_rdata,
  output logic        dm_resp_valid,
  output logic [63:0] bus_req_addr,
  output logic [63:0] bus_req_wdata,
  output logic [7:0]  bus_req_wmask,
  output logic        bus_req_wen,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  input  logic [63:0] bus_resp_rdata,
  input  logic        bus_resp_err,
  input  logic        bus_resp_valid,
  output logic        dm_bus_err,
  output logic        dm_busy
);

`ifdef DMEM_BRIDGE_POSTED_WRITE_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  localparam int unsigned CW = ($clog2(TIMEOUT_CYCLES) > 8) ? $clog2(TIMEOUT_CYCLES) : 8;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;

  logic [63:0] req_addr, req_wdata;
  logic [7:0]  req_wmask;
  logic        req_wen;

  logic        pend_vld;
  logic [63:0] pend_addr, pend_wdata;
  logic [7:0]  pend_wmask;
  logic        pend_wen;

  logic to_hit, resp_hit, exit_txn, issue_new, issue_pend, pend_set;
  logic is_posted, ack_now, pend_ok;
  logic unused_addr_lsb;

  assign unused_addr_lsb = ^dm_req_addr[2:0];

  assign bus_req_addr  = req_addr;
  assign bus_req_wdata = req_wdata;
  assign bus_req_wmask = req_wmask;
  assign bus_req_wen   = req_wen;
  assign dm_busy       = (state != IDLE);

  // A posted store is acknowledged in its first REQ cycle and completes silently afterwards.
  assign is_posted = POSTED && req_wen;
  assign ack_now   = is_posted && (state == REQ) && (cnt == '0);
  assign pend_ok   = (state == DRAIN) || (is_posted && (state == REQ || state == WAIT));

  assign to_hit    = (state == REQ || state == WAIT) && (cnt == CNT_LAST);
  assign resp_hit  = (state == WAIT) && bus_resp_valid;

  always_comb begin
    bus_req_valid = (state == REQ) && !to_hit;
    dm_resp_valid = 1'b0;
    dm_resp_rdata = '0;
    dm_bus_err    = 1'b0;
    // A real response beats a timeout that lands in the same cycle.
    if (resp_hit) begin
      dm_bus_err = bus_resp_err;
      if (!is_posted) begin
        dm_resp_valid = 1'b1;
        dm_resp_rdata = bus_resp_err ? ERR_RDATA : bus_resp_rdata;
      end
    end else if (to_hit) begin
      dm_bus_err = 1'b1;
      if (!is_posted) begin
        dm_resp_valid = 1'b1;
        dm_resp_rdata = ERR_RDATA;
      end
    end else if (ack_now) begin
      dm_resp_valid = 1'b1;
    end
  end

  always_comb begin
    state_nxt  = state;
    exit_txn   = 1'b0;
    issue_new  = 1'b0;
    issue_pend = 1'b0;
    pend_set   = 1'b0;
    case (state)
      IDLE: begin
        if (dm_req_valid) begin
          state_nxt = REQ;
          issue_new = 1'b1;
        end
      end
      REQ: begin
        if (to_hit)             exit_txn  = 1'b1;
        else if (bus_req_ready) state_nxt = WAIT;
      end
      WAIT: begin
        if (resp_hit)    exit_txn  = 1'b1;
        else if (to_hit) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (bus_resp_valid) exit_txn = 1'b1;
      end
    endcase
    // Leaving a transaction goes straight to REQ when a request is waiting.
    if (exit_txn) begin
      if (pend_vld) begin
        state_nxt  = REQ;
        issue_pend = 1'b1;
      end else if (dm_req_valid && pend_ok) begin
        state_nxt = REQ;
        issue_new = 1'b1;
      end else begin
        state_nxt = IDLE;
      end
    end else if (dm_req_valid && pend_ok && !pend_vld) begin
      pend_set = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      req_addr   <= '0;
      req_wdata  <= '0;
      req_wmask  <= '0;
      req_wen    <= 1'b0;
      pend_vld   <= 1'b0;
      pend_addr  <= '0;
      pend_wdata <= '0;
      pend_wmask <= '0;
      pend_wen   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (issue_new || issue_pend)
        cnt <= '0;
      else if (state == REQ || state == WAIT)
        cnt <= cnt + CW'(1);

      if (issue_new) begin
        req_addr  <= {dm_req_addr[63:3], 3'b000};
        req_wdata <= dm_req_wdata;
        req_wmask <= dm_req_wen ? dm_req_wmask : 8'h00;
        req_wen   <= dm_req_wen;
      end else if (issue_pend) begin
        req_addr  <= pend_addr;
        req_wdata <= pend_wdata;
        req_wmask <= pend_wmask;
        req_wen   <= pend_wen;
      end

      if (issue_pend) begin
        pend_vld <= 1'b0;
      end else if (pend_set) begin
        pend_vld   <= 1'b1;
        pend_addr  <= {dm_req_addr[63:3], 3'b000};
        pend_wdata <= dm_req_wdata;
        pend_wmask <= dm_req_wen ? dm_req_wmask : 8'h00;
        pend_wen   <= dm_req_wen;
      end
    end
  end

endmodule

// File: tb/tb_dmem_bridge.sv
// Bench for dmem_bridge: a cycle timeline of expected outputs is built per transaction by arithmetic,
// then replayed against the DUT with a per-cycle compare and a few literal pins.
module tb_dmem_bridge;
  localparam int T  = 8;
  localparam int NC = 3000;
  localparam logic [63:0] ERRD = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [63:0] dm_req_addr = '0, dm_req_wdata = '0;
  logic [7:0]  dm_req_wmask = '0;
  logic        dm_req_wen = 1'b0, dm_req_valid = 1'b0;
  logic [63:0] dm_resp_rdata;
  logic        dm_resp_valid;
  logic [63:0] bus_req_addr, bus_req_wdata;
  logic [7:0]  bus_req_wmask;
  logic        bus_req_wen, bus_req_valid;
  logic        bus_req_ready = 1'b0;
  logic [63:0] bus_resp_rdata = '0;
  logic        bus_resp_err = 1'b0, bus_resp_valid = 1'b0;
  logic        dm_bus_err, dm_busy;

  always #5 clk = ~clk;

  dmem_bridge #(.TIMEOUT_CYCLES(T), .ERR_RDATA(ERRD)) dut (
    .clk(clk), .rst(rst),
    .dm_req_addr(dm_req_addr), .dm_req_wdata(dm_req_wdata), .dm_req_wmask(dm_req_wmask),
    .dm_req_wen(dm_req_wen), .dm_req_valid(dm_req_valid),
    .dm_resp_rdata(dm_resp_rdata), .dm_resp_valid(dm_resp_valid),
    .bus_req_addr(bus_req_addr), .bus_req_wdata(bus_req_wdata), .bus_req_wmask(bus_req_wmask),
    .bus_req_wen(bus_req_wen), .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
    .bus_resp_rdata(bus_resp_rdata), .bus_resp_err(bus_resp_err), .bus_resp_valid(bus_resp_valid),
    .dm_bus_err(dm_bus_err), .dm_busy(dm_busy)
  );

  // Stimulus timeline
  logic        drv_rst [NC];
  logic        drv_req [NC];
  logic [63:0] drv_addr [NC];
  logic [63:0] drv_wdata [NC];
  logic [7:0]  drv_wmask [NC];
  logic        drv_wen [NC];
  logic        drv_ready [NC];
  logic        drv_resp [NC];
  logic [63:0] drv_rdata [NC];
  logic        drv_err [NC];
  // Expected timeline
  logic        exp_busy [NC];
  logic        exp_rw [NC];
  logic        exp_bvld [NC];
  logic [63:0] exp_baddr [NC];
  logic [63:0] exp_bwdata [NC];
  logic [7:0]  exp_bwmask [NC];
  logic        exp_bwen [NC];
  logic        exp_resp [NC];
  logic        exp_err [NC];
  logic        exp_rchk [NC];
  logic [63:0] exp_rdata [NC];

  int cyc = -1;
  int last_c = 0;
  int rst_pin = 0;
  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
  endtask

  task automatic mark_resp(input int c, input logic er, input logic [63:0] rd, input logic load);
    exp_resp[c]  = 1'b1;
    exp_err[c]   = er;
    exp_rdata[c] = rd;
    exp_rchk[c]  = load;
  endtask

  task automatic drive_bus_req(input int c, input logic [63:0] ba, input logic [63:0] wd,
                               input logic [7:0] bm, input logic we);
    exp_bvld[c]   = 1'b1;
    exp_baddr[c]  = ba;
    exp_bwdata[c] = wd;
    exp_bwmask[c] = bm;
    exp_bwen[c]   = we;
  endtask

  // d = cycles with ready low before the handshake (d >= T-1: never ready), l = response latency after ready.
  task automatic sched_txn(input int s, input int r0, input logic [63:0] a, input logic [63:0] wd,
                           input logic [7:0] wm, input logic we, input int d, input int l,
                           input logic er, input logic [63:0] rd, output int end_c, output int drain_c);
    logic [63:0] ba;
    logic [7:0]  bm;
    int rc;
    ba = a & ~64'h7;
    bm = we ? wm : 8'h00;
    drv_req[s] = 1'b1; drv_addr[s] = a; drv_wdata[s] = wd; drv_wmask[s] = wm; drv_wen[s] = we;
    drain_c = -1;
    if (d >= T - 1) begin
      for (int k = 0; k < T; k++) begin
        if (k < T - 1) drive_bus_req(r0 + k, ba, wd, bm, we);
        drv_ready[r0 + k] = 1'b0;
        drv_resp[r0 + k]  = ($urandom_range(0, 3) == 0);
      end
      mark_resp(r0 + T - 1, 1'b1, ERRD, !we);
      end_c = r0 + T - 1;
      for (int c = r0; c <= end_c; c++) exp_rw[c] = 1'b1;
    end else begin
      for (int k = 0; k <= d; k++) begin
        drive_bus_req(r0 + k, ba, wd, bm, we);
        drv_ready[r0 + k] = (k == d);
        if (k < d) drv_resp[r0 + k] = ($urandom_range(0, 3) == 0);
      end
      rc = r0 + d + l;
      drv_resp[rc] = 1'b1; drv_rdata[rc] = rd; drv_err[rc] = er;
      end_c = rc;
      if (d + l < T - 1) begin
        mark_resp(rc, er, er ? ERRD : rd, !we);
        for (int c = r0; c <= rc; c++) exp_rw[c] = 1'b1;
      end else begin
        mark_resp(r0 + T - 1, 1'b1, ERRD, !we);
        for (int c = r0; c <= r0 + T - 1; c++) exp_rw[c] = 1'b1;
        drain_c = r0 + T;
      end
    end
    for (int c = r0; c <= end_c; c++) exp_busy[c] = 1'b1;
  endtask

  initial begin
    int e, dr, s, r0, d, l, x, gap;
    logic we, er;
    for (int c = 0; c < NC; c++) begin
      drv_rst[c] = (c >= 2);
      drv_req[c] = 1'b0;
      drv_addr[c] = {$urandom, $urandom};
      drv_wdata[c] = {$urandom, $urandom};
      drv_wmask[c] = 8'($urandom);
      drv_wen[c] = 1'($urandom);
      drv_ready[c] = 1'($urandom);
      drv_resp[c] = 1'b0;
      drv_rdata[c] = {$urandom, $urandom};
      drv_err[c] = 1'($urandom);
      exp_busy[c] = 1'b0; exp_rw[c] = 1'b0; exp_bvld[c] = 1'b0;
      exp_baddr[c] = '0; exp_bwdata[c] = '0; exp_bwmask[c] = '0; exp_bwen[c] = 1'b0;
      exp_resp[c] = 1'b0; exp_err[c] = 1'b0; exp_rchk[c] = 1'b0; exp_rdata[c] = '0;
    end
    // Directed: zero-wait load, stalled store, REQ timeout, WAIT timeout + drain + pending load, error load.
    sched_txn(3, 4, 64'h1003, 64'h0, 8'hFF, 1'b0, 0, 1, 1'b0, 64'h1122334455667788, e, dr);
    sched_txn(6, 7, 64'h2008, 64'hCAFE_F00D_CAFE_F00D, 8'h0F, 1'b1, 3, 1, 1'b0, 64'h0, e, dr);
    sched_txn(12, 13, 64'h4000, 64'h0, 8'h00, 1'b0, T - 1, 1, 1'b0, 64'h0, e, dr);
    sched_txn(21, 22, 64'h5000, 64'h0, 8'h00, 1'b0, 0, 12, 1'b0, 64'hBAD0_BAD0_BAD0_BAD0, e, dr);
    sched_txn(31, 35, 64'h3010, 64'h0, 8'h00, 1'b0, 0, 1, 1'b0, 64'hA5A5_0F0F_1234_5678, e, dr);
    sched_txn(37, 38, 64'h6000, 64'h0, 8'h00, 1'b0, 1, 2, 1'b1, 64'h0123_4567_89AB_CDEF, e, dr);
    // Random traffic
    while (e < NC - 80) begin
      x = $urandom_range(0, 9);
      d = $urandom_range(0, 3);
      l = $urandom_range(1, 3);
      if (x == 7 || x == 8) l = T - d + $urandom_range(0, 4);
      if (x == 9) d = T - 1;
      we = 1'($urandom);
      er = ($urandom_range(0, 7) == 0);
      if (dr >= 0 && $urandom_range(0, 1) == 1) begin
        s = $urandom_range(dr, e);
        r0 = e + 1;
      end else begin
        gap = $urandom_range(0, 2);
        s = e + 1 + gap;
        r0 = s + 1;
        for (int c = e + 1; c <= s; c++) drv_resp[c] = ($urandom_range(0, 2) == 0);
      end
      sched_txn(s, r0, {$urandom, $urandom}, {$urandom, $urandom}, 8'($urandom), we, d, l, er,
                {$urandom, $urandom}, e, dr);
    end
    // Reset while in WAIT, stray response afterwards, then a normal load.
    s = e + 2;
    r0 = s + 1;
    drv_req[s] = 1'b1; drv_addr[s] = 64'h7777_0000_0000_1238; drv_wen[s] = 1'b0;
    drive_bus_req(r0, 64'h7777_0000_0000_1238, drv_wdata[s], 8'h00, 1'b0);
    drv_ready[r0] = 1'b1;
    for (int c = r0; c <= r0 + 2; c++) begin exp_busy[c] = 1'b1; exp_rw[c] = 1'b1; end
    drv_rst[r0 + 2] = 1'b0;
    drv_resp[r0 + 4] = 1'b1; drv_err[r0 + 4] = 1'b0;
    rst_pin = r0 + 3;
    sched_txn(r0 + 6, r0 + 7, 64'h8000_0000_0000_0010, 64'h0, 8'h00, 1'b0, 0, 1, 1'b0,
              64'h5555_6666_7777_8888, e, dr);
    last_c = e + 3;

    for (int k = 0; k <= last_c; k++) begin
      @(posedge clk);
      cyc = k;
      #1;
      rst            = drv_rst[k];
      dm_req_valid   = drv_req[k];
      dm_req_addr    = drv_addr[k];
      dm_req_wdata   = drv_wdata[k];
      dm_req_wmask   = drv_wmask[k];
      dm_req_wen     = drv_wen[k];
      bus_req_ready  = drv_ready[k];
      bus_resp_valid = drv_resp[k];
      bus_resp_rdata = drv_rdata[k];
      bus_resp_err   = drv_err[k];
    end
    @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  always @(negedge clk) begin
    if (cyc >= 0 && cyc <= last_c) begin
      assert (!(dm_req_valid && exp_rw[cyc])) else $error("protocol: dm_req_valid while in flight, cycle %0d", cyc);
      check("dm_busy", 64'(dm_busy), 64'(exp_busy[cyc]));
      check("bus_req_valid", 64'(bus_req_valid), 64'(exp_bvld[cyc]));
      check("dm_resp_valid", 64'(dm_resp_valid), 64'(exp_resp[cyc]));
      check("dm_bus_err", 64'(dm_bus_err), 64'(exp_err[cyc]));
      if (exp_bvld[cyc]) begin
        check("bus_req_addr", bus_req_addr, exp_baddr[cyc]);
        check("bus_req_wdata", bus_req_wdata, exp_bwdata[cyc]);
        check("bus_req_wmask", 64'(bus_req_wmask), 64'(exp_bwmask[cyc]));
        check("bus_req_wen", 64'(bus_req_wen), 64'(exp_bwen[cyc]));
      end
      if (exp_resp[cyc] && exp_rchk[cyc]) check("dm_resp_rdata", dm_resp_rdata, exp_rdata[cyc]);
      // Literal pins on the directed part of the timeline
      if (cyc == 2) begin
        check("rst_bus_req_addr", bus_req_addr, 64'h0);
        check("rst_bus_req_wdata", bus_req_wdata, 64'h0);
        check("rst_bus_req_wmask", 64'(bus_req_wmask), 64'h0);
        check("rst_dm_resp_rdata", dm_resp_rdata, 64'h0);
      end
      if (cyc == 4) begin
        check("pin_load_addr", bus_req_addr, 64'h1000);
        check("pin_load_wmask", 64'(bus_req_wmask), 64'h0);
      end
      if (cyc == 5) begin
        check("pin_load_vld", 64'(dm_resp_valid), 64'h1);
        check("pin_load_rdata", dm_resp_rdata, 64'h1122334455667788);
      end
      if (cyc == 9) begin
        check("pin_store_addr", bus_req_addr, 64'h2008);
        check("pin_store_wmask", 64'(bus_req_wmask), 64'h0F);
      end
      if (cyc == 10) check("pin_store_early", 64'(dm_resp_valid), 64'h0);
      if (cyc == 11) check("pin_store_done", 64'(dm_resp_valid), 64'h1);
      if (cyc == 20) begin
        check("pin_to_req_err", 64'(dm_bus_err), 64'h1);
        check("pin_to_req_rdata", dm_resp_rdata, ERRD);
        check("pin_to_req_bvld", 64'(bus_req_valid), 64'h0);
      end
      if (cyc == 29) check("pin_to_wait_err", 64'(dm_bus_err), 64'h1);
      if (cyc == 34) check("pin_drain_discard", 64'(dm_resp_valid), 64'h0);
      if (cyc == 36) check("pin_pend_rdata", dm_resp_rdata, 64'hA5A5_0F0F_1234_5678);
      if (cyc == 41) begin
        check("pin_err_flag", 64'(dm_bus_err), 64'h1);
        check("pin_err_rdata", dm_resp_rdata, ERRD);
      end
      if (cyc == rst_pin) check("pin_rst_addr_cleared", bus_req_addr, 64'h0);
    end
  end

endmodule
